// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divider: FSM state encoding and
// step-counter sizing.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } div_state_e;

    function automatic int cnt_width(input int w);
        int c;
        c = $clog2(w);
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep or restore, emit the quotient bit.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-2:0] r_in,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_out,
    output logic             q_bit
);

    logic signed [WIDTH:0] trial;

    // One extra bit so the sign of the trial difference shows a borrow.
    assign trial = $signed({1'b0, r_in, q_msb}) - $signed({1'b0, d});
    assign q_bit = ~trial[WIDTH];
    assign r_out = q_bit ? trial[WIDTH-1:0] : {r_in, q_msb};

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per clock, valid/ready
// on both sides. Define SEQ_DIV_SIGNED_EN for two's-complement operands.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_zero_o
);

    localparam int CW = cnt_width(WIDTH);

    div_state_e       state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-2:0] rem_p0;
    logic [WIDTH-1:0] quo_p0;
    logic [WIDTH-1:0] dvs_p0;
    logic             accept;
    logic             zero_div;
    logic             step_bit;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] quo_fin;
    logic [WIDTH-1:0] rem_fin;

    assign accept   = valid_i && ready_o;
    assign zero_div = (divisor_i == '0);
    assign quo_nxt  = {quo_p0[WIDTH-2:0], step_bit};

`ifdef SEQ_DIV_SIGNED_EN
    logic neg_q_p0;
    logic neg_r_p0;

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                    input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign dvd_mag = apply_sign(dividend_i, dividend_i[WIDTH-1]);
    assign dvs_mag = apply_sign(divisor_i, divisor_i[WIDTH-1]);
    assign quo_fin = apply_sign(quo_nxt, neg_q_p0);
    assign rem_fin = apply_sign(step_rem, neg_r_p0);

    always_ff @(posedge clk_i) begin
        if (accept) begin
            neg_q_p0 <= dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
            neg_r_p0 <= dividend_i[WIDTH-1];
        end
    end
`else
    assign dvd_mag = dividend_i;
    assign dvs_mag = divisor_i;
    assign quo_fin = quo_nxt;
    assign rem_fin = step_rem;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_in  (rem_p0),
        .q_msb (quo_p0[WIDTH-1]),
        .d     (dvs_p0),
        .r_out (step_rem),
        .q_bit (step_bit)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (valid_i) state_nxt = zero_div ? ST_DONE : ST_BUSY;
            ST_BUSY: if (cnt == '0) state_nxt = ST_DONE;
            ST_DONE: if (ready_i) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_o = (state == ST_IDLE);
        valid_o = (state == ST_DONE);
    end

    // Result registers only change on accept or the final step, so they hold through DONE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt         <= '0;
            quotient_o  <= '0;
            remainder_o <= '0;
            div_zero_o  <= 1'b0;
        end else if (accept) begin
            div_zero_o <= zero_div;
            if (zero_div) begin
                quotient_o  <= '1;
                remainder_o <= dividend_i;
            end else begin
                cnt    <= CW'(WIDTH - 1);
                rem_p0 <= '0;
                quo_p0 <= dvd_mag;
                dvs_p0 <= dvs_mag;
            end
        end else if (state == ST_BUSY) begin
            rem_p0 <= step_rem[WIDTH-2:0];
            quo_p0 <= quo_nxt;
            if (cnt == '0) begin
                quotient_o  <= quo_fin;
                remainder_o <= rem_fin;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule
